relay_scheduler: RTL and testbench

Round-robin scheduler that shares one pulse-sampling timer among `NUM_CH` AUX inputs. Each scan visit captures one symbol from one channel: the level a fixed delay after a rising edge. Each channel's symbols are debounced over `CONFIRM` consecutive agreeing samples, and the confirmed level drives that channel's relay. After any relay change, a global dead time is inserted before the next visit. It sits between the board AUX inputs and the relay/LED drivers.

---
 rtl/relay_scheduler.sv | 256 +++++++++++++++++++++++++
 tb/tb_relay_scheduler.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/relay_scheduler.sv
// relay_scheduler: one shared sampling timer visits each enabled AUX channel
// in turn. A visit samples the channel level a fixed delay after a rising
// edge. Each channel debounces its samples, and the confirmed level drives
// that channel's relay. A dead time follows any relay change.
//
// state     | meaning
// IDLE      | no channel enabled
// SELECT    | pick next enabled channel after ptr, clear timer
// WAIT_EDGE | wait for a rising edge on the visited channel (timeout)
// DELAY     | count to the sample point, capture the level
// EVAL      | debounce update and relay decision
// WAIT_LOW  | wait for the visited channel to return low (timeout)
// DEAD      | hold off after a relay change; no channel visited

module relay_scheduler #(
  parameter int NUM_CH       = 4,
  parameter int SAMPLE_DELAY = 75000,
  parameter int CONFIRM      = 5,
  parameter int TIMEOUT      = 2500000,
  parameter int DEAD_TIME    = 50000
) (
  input  logic                      CLOCK_50,
  input  logic                      RESET_N,
  input  logic [NUM_CH-1:0]         AUX_INPUT,
  input  logic [NUM_CH-1:0]         CH_ENABLE,
  output logic [NUM_CH-1:0]         RELAY_OUT,
  output logic [NUM_CH-1:0]         CH_VALID,
  output logic [NUM_CH-1:0]         ERR_TIMEOUT,
  output logic [$clog2(NUM_CH)-1:0] BUSY_CH
);

  localparam int CW      = $clog2(NUM_CH);
  localparam int MAX_AB  = (SAMPLE_DELAY > TIMEOUT) ? SAMPLE_DELAY : TIMEOUT;
  localparam int MAX_CNT = (MAX_AB > DEAD_TIME) ? MAX_AB : DEAD_TIME;
  localparam int TW      = $clog2(MAX_CNT);

  localparam logic [TW-1:0] SD_LAST   = TW'(SAMPLE_DELAY - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] DT_LAST   = TW'(DEAD_TIME - 1);
  localparam logic [3:0]    CONFIRM_N = 4'(CONFIRM);

  typedef enum logic [2:0] {
    S_IDLE, S_SELECT, S_WAIT_EDGE, S_DELAY, S_EVAL, S_WAIT_LOW, S_DEAD
  } state_t;

  logic [NUM_CH-1:0] sync1_q, s_q, p_q;
  logic [NUM_CH-1:0] relay_q, valid_q, err_q, cand_q;
  logic [3:0]        agree_q [NUM_CH];

  state_t            state_q, state_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [CW-1:0]     ptr_q, ptr_d;
  logic [CW-1:0]     busy_q, busy_d;
  logic              bit_q, bit_d;
  logic              dead_q, dead_d;

  logic              eval_go, tmo_go;
  logic [CW-1:0]     nxt_idx, idx;
  logic              found;
  logic              cand_new, decide;
  logic [3:0]        agree_new;

  logic              s_cur, edge_cur, en_cur, any_en, tmo_hit, visiting;

  assign s_cur    = s_q[ptr_q];
  assign edge_cur = s_q[ptr_q] & ~p_q[ptr_q];
  assign en_cur   = CH_ENABLE[ptr_q];
  assign any_en   = |CH_ENABLE;
  assign tmo_hit  = (timer_q == TO_LAST);
  assign visiting = (state_q == S_WAIT_EDGE) || (state_q == S_DELAY) ||
                    (state_q == S_EVAL) || (state_q == S_WAIT_LOW);

  // Two-flop synchronizers plus a delayed copy for rising-edge detection.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      sync1_q <= '0;
      s_q     <= '0;
      p_q     <= '0;
    end else begin
      sync1_q <= AUX_INPUT;
      s_q     <= sync1_q;
      p_q     <= s_q;
    end
  end

  // Next enabled channel after ptr, wrapping; falls back to ptr itself.
  always_comb begin
    nxt_idx = ptr_q;
    found   = 1'b0;
    idx     = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      idx = CW'((int'(ptr_q) + k) % NUM_CH);
      if (!found && CH_ENABLE[idx]) begin
        nxt_idx = idx;
        found   = 1'b1;
      end
    end
  end

  // Debounce arithmetic for the visited channel, used only in EVAL.
  always_comb begin
    cand_new  = bit_q;
    agree_new = 4'd1;
    if ((agree_q[ptr_q] != 4'd0) && (bit_q == cand_q[ptr_q])) begin
      cand_new  = cand_q[ptr_q];
      agree_new = agree_q[ptr_q] + 4'd1;
    end
    decide = (agree_new == CONFIRM_N);
  end

  // Scan FSM: next state, shared timer, pointer and visit strobes.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    ptr_d   = ptr_q;
    busy_d  = busy_q;
    bit_d   = bit_q;
    dead_d  = dead_q;
    eval_go = 1'b0;
    tmo_go  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (any_en) state_d = S_SELECT;
      end
      S_SELECT: begin
        ptr_d   = nxt_idx;
        busy_d  = nxt_idx;
        timer_d = '0;
        state_d = S_WAIT_EDGE;
      end
      S_WAIT_EDGE: begin
        if (edge_cur) begin
          timer_d = '0;
          state_d = S_DELAY;
        end else if (tmo_hit) begin
          tmo_go  = 1'b1;
          state_d = S_SELECT;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_DELAY: begin
        if (timer_q == SD_LAST) begin
          bit_d   = s_cur;
          state_d = S_EVAL;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_EVAL: begin
        eval_go = 1'b1;
        if (decide && (relay_q[ptr_q] != cand_new)) dead_d = 1'b1;
        timer_d = '0;
        state_d = S_WAIT_LOW;
      end
      S_WAIT_LOW: begin
        if (!s_cur) begin
          timer_d = '0;
          state_d = dead_q ? S_DEAD : S_SELECT;
        end else if (tmo_hit) begin
          tmo_go  = 1'b1;
          state_d = S_SELECT;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_DEAD: begin
        if (timer_q == DT_LAST) begin
          dead_d  = 1'b0;
          state_d = S_SELECT;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Visited channel disabled: drop the visit. Its relay is being released
    // by the disable, so no hold-off is kept pending for it.
    if (visiting && !en_cur) begin
      state_d = S_SELECT;
      eval_go = 1'b0;
      tmo_go  = 1'b0;
      dead_d  = 1'b0;
      bit_d   = bit_q;
    end

    // Nothing left to scan; an in-progress dead time still runs out first.
    if (!any_en && (state_q != S_DEAD)) begin
      state_d = S_IDLE;
      ptr_d   = ptr_q;
      busy_d  = busy_q;
      eval_go = 1'b0;
      tmo_go  = 1'b0;
      dead_d  = 1'b0;
    end
  end

  // FSM and shared datapath registers.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      ptr_q   <= CW'(NUM_CH - 1);
      busy_q  <= '0;
      bit_q   <= 1'b0;
      dead_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      ptr_q   <= ptr_d;
      busy_q  <= busy_d;
      bit_q   <= bit_d;
      dead_q  <= dead_d;
    end
  end

  // Per-channel debounce, relay, valid and sticky timeout state.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      relay_q <= '0;
      valid_q <= '0;
      err_q   <= '0;
      cand_q  <= '0;
      for (int i = 0; i < NUM_CH; i++) agree_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (!CH_ENABLE[i]) begin
          relay_q[i] <= 1'b0;
          valid_q[i] <= 1'b0;
          err_q[i]   <= 1'b0;
          cand_q[i]  <= 1'b0;
          agree_q[i] <= '0;
        end else if (eval_go && (ptr_q == CW'(i))) begin
          cand_q[i]  <= cand_new;
          agree_q[i] <= decide ? 4'd0 : agree_new;
          if (decide) begin
            valid_q[i] <= 1'b1;
            relay_q[i] <= cand_new;
          end
        end else if (tmo_go && (ptr_q == CW'(i))) begin
          err_q[i]   <= 1'b1;
          valid_q[i] <= 1'b0;
          agree_q[i] <= '0;
        end
      end
    end
  end

  assign RELAY_OUT   = relay_q;
  assign CH_VALID    = valid_q;
  assign ERR_TIMEOUT = err_q;
  assign BUSY_CH     = busy_q;

endmodule

// File: tb/tb_relay_scheduler.sv
// Directed bench for relay_scheduler with small timing parameters
// (SAMPLE_DELAY=8, CONFIRM=3, TIMEOUT=64, DEAD_TIME=16).

module tb_relay_scheduler;

  logic       CLOCK_50;
  logic       RESET_N;
  logic [3:0] AUX_INPUT;
  logic [3:0] CH_ENABLE;
  logic [3:0] RELAY_OUT;
  logic [3:0] CH_VALID;
  logic [3:0] ERR_TIMEOUT;
  logic [1:0] BUSY_CH;

  logic [3:0] aux_man;
  logic [3:0] aux_auto;
  int         gen_cnt;
  int         checks;
  int         failures;

  int         hi_len [5] = '{20, 4, 20, 20, 20};
  int         exp_rr [6] = '{0, 1, 3, 0, 1, 3};
  int         seq    [6];
  int         nseq;
  int         seen2;
  logic [1:0] last_busy;

  relay_scheduler #(
    .NUM_CH(4), .SAMPLE_DELAY(8), .CONFIRM(3), .TIMEOUT(64), .DEAD_TIME(16)
  ) dut (
    .CLOCK_50   (CLOCK_50),
    .RESET_N    (RESET_N),
    .AUX_INPUT  (AUX_INPUT),
    .CH_ENABLE  (CH_ENABLE),
    .RELAY_OUT  (RELAY_OUT),
    .CH_VALID   (CH_VALID),
    .ERR_TIMEOUT(ERR_TIMEOUT),
    .BUSY_CH    (BUSY_CH)
  );

  initial begin
    CLOCK_50 = 1'b0;
    forever #5 CLOCK_50 = ~CLOCK_50;
  end

  // AUX driver: applies manual levels plus optional 20-high/20-low pulses
  // one time step after each rising edge.
  initial begin
    gen_cnt   = 0;
    AUX_INPUT = '0;
    forever begin
      @(posedge CLOCK_50);
      #1;
      gen_cnt++;
      AUX_INPUT = aux_man | (aux_auto & {4{(gen_cnt % 40) < 20}});
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge CLOCK_50);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_busy(input logic [1:0] v, input int budget);
    int n;
    n = 0;
    while ((BUSY_CH !== v) && (n < budget)) begin
      @(negedge CLOCK_50);
      n++;
    end
    if (BUSY_CH !== v) begin
      checks++;
      failures++;
      $error("FAIL wait_busy observed=%0d expected=%0d", BUSY_CH, v);
    end
  endtask

  task automatic do_reset(input logic [3:0] en);
    RESET_N  = 1'b0;
    CH_ENABLE = en;
    aux_man  = '0;
    aux_auto = '0;
    cyc(3);
    RESET_N  = 1'b1;
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    RESET_N   = 1'b0;
    CH_ENABLE = 4'b0001;
    aux_man   = '0;
    aux_auto  = '0;

    // Reset values, then three full pulses on ch0.
    cyc(3);
    chk("rst_relay", 32'(RELAY_OUT), 32'h0);
    chk("rst_valid", 32'(CH_VALID), 32'h0);
    chk("rst_err",   32'(ERR_TIMEOUT), 32'h0);
    chk("rst_busy",  32'(BUSY_CH), 32'h0);
    RESET_N = 1'b1;
    cyc(20);
    for (int i = 0; i < 3; i++) begin
      aux_man[0] = 1'b1;
      if (i == 2) begin
        cyc(12);
        chk("basic_relay_pre", 32'(RELAY_OUT[0]), 32'h0);
        chk("basic_valid_pre", 32'(CH_VALID[0]), 32'h0);
        cyc(1);
        chk("basic_relay_post", 32'(RELAY_OUT[0]), 32'h1);
        chk("basic_valid_post", 32'(CH_VALID[0]), 32'h1);
        cyc(7);
      end else begin
        cyc(20);
        chk("basic_valid_early", 32'(CH_VALID[0]), 32'h0);
      end
      aux_man[0] = 1'b0;
      cyc(20);
    end

    // Debounce: samples 1,0,1,1,1 decide only on the fifth pulse.
    do_reset(4'b0001);
    cyc(20);
    for (int i = 0; i < 5; i++) begin
      aux_man[0] = 1'b1;
      if (i == 4) begin
        cyc(12);
        chk("deb_relay_pre", 32'(RELAY_OUT[0]), 32'h0);
        cyc(1);
        chk("deb_relay_post", 32'(RELAY_OUT[0]), 32'h1);
        chk("deb_valid_post", 32'(CH_VALID[0]), 32'h1);
        cyc(hi_len[i] - 13);
      end else begin
        cyc(hi_len[i]);
      end
      aux_man[0] = 1'b0;
      cyc(20);
      if (i == 3) begin
        chk("deb_relay_p4", 32'(RELAY_OUT[0]), 32'h0);
        chk("deb_valid_p4", 32'(CH_VALID[0]), 32'h0);
      end
    end

    // Round-robin over 4'b1011 with every channel pulsing.
    do_reset(4'b1011);
    aux_auto  = 4'b1111;
    for (int i = 0; i < 6; i++) seq[i] = -1;
    seq[0]    = int'(BUSY_CH);
    nseq      = 1;
    seen2     = 0;
    last_busy = BUSY_CH;
    for (int n = 0; n < 1500; n++) begin
      cyc(1);
      if (BUSY_CH == 2'd2) seen2++;
      if (BUSY_CH != last_busy) begin
        if (nseq < 6) seq[nseq] = int'(BUSY_CH);
        nseq++;
        last_busy = BUSY_CH;
      end
    end
    for (int i = 0; i < 6; i++) chk($sformatf("rr_seq%0d", i), 32'(seq[i]), 32'(exp_rr[i]));
    chk("rr_ch2_visits", 32'(seen2), 32'h0);
    chk("rr_valid", 32'(CH_VALID), 32'hb);
    chk("rr_relay", 32'(RELAY_OUT), 32'hb);

    // Timeout on ch1 held low; ch0 keeps being scanned.
    do_reset(4'b0011);
    aux_auto = 4'b0001;
    wait_busy(2'd1, 500);
    cyc(63);
    chk("tmo_err_pre", 32'(ERR_TIMEOUT[1]), 32'h0);
    cyc(1);
    chk("tmo_err_post", 32'(ERR_TIMEOUT[1]), 32'h1);
    chk("tmo_valid1", 32'(CH_VALID[1]), 32'h0);
    cyc(1);
    chk("tmo_busy_back", 32'(BUSY_CH), 32'h0);
    cyc(600);
    chk("tmo_relay0", 32'(RELAY_OUT[0]), 32'h1);
    chk("tmo_valid", 32'(CH_VALID), 32'h1);
    chk("tmo_err_all", 32'(ERR_TIMEOUT), 32'h2);

    // Dead time: only the third pulse flips the relay; the sixth decides
    // the same level and must not add a hold-off.
    do_reset(4'b0011);
    cyc(3);
    for (int i = 0; i < 6; i++) begin
      int dly;
      dly = (i == 2) ? 20 : 4;
      if (i > 0) wait_busy(2'd0, 200);
      aux_man[0] = 1'b1;
      cyc(20);
      aux_man[0] = 1'b0;
      cyc(dly);
      chk($sformatf("dead_hold%0d", i), 32'(BUSY_CH), 32'h0);
      cyc(1);
      chk($sformatf("dead_sel%0d", i), 32'(BUSY_CH), 32'h1);
    end
    chk("dead_relay0", 32'(RELAY_OUT[0]), 32'h1);
    chk("dead_valid0", 32'(CH_VALID[0]), 32'h1);

    // Disable ch0 in the middle of DELAY.
    wait_busy(2'd0, 200);
    aux_man[0] = 1'b1;
    cyc(6);
    CH_ENABLE = 4'b0010;
    cyc(1);
    chk("dis_relay0", 32'(RELAY_OUT[0]), 32'h0);
    chk("dis_valid0", 32'(CH_VALID[0]), 32'h0);
    chk("dis_busy_sel", 32'(BUSY_CH), 32'h0);
    cyc(1);
    chk("dis_busy_next", 32'(BUSY_CH), 32'h1);
    aux_man[0] = 1'b0;
    cyc(2);
    CH_ENABLE = 4'b0011;

    // Asynchronous reset in the middle of DELAY.
    wait_busy(2'd0, 200);
    aux_man[0] = 1'b1;
    cyc(6);
    chk("arst_err_pre", 32'(ERR_TIMEOUT[1]), 32'h1);
    #2;
    RESET_N = 1'b0;
    #1;
    chk("arst_relay", 32'(RELAY_OUT), 32'h0);
    chk("arst_valid", 32'(CH_VALID), 32'h0);
    chk("arst_err",   32'(ERR_TIMEOUT), 32'h0);
    chk("arst_busy",  32'(BUSY_CH), 32'h0);
    cyc(1);
    aux_man = '0;
    RESET_N = 1'b1;
    cyc(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
